// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Writeback stage in front of the register file's single write port.
//   Merges a one-cycle ALU result channel and a buffered load-return
//   channel. A starvation guard forces a load drain after MAX_STARVE
//   consecutive ALU wins over a non-empty FIFO. Writes to R15 go to the
//   PC-load output instead of the register file.
//
// Optional feature macro: WB_PERF_COUNT_EN
//   Adds saturating stall_count / full_count perf counters.
//
// Ports
//   clk, reset                 clock, async active-low reset
//   alu_valid/rd/data          ALU result in
//   alu_stall                  ALU result not taken this cycle, re-present
//   mem_valid/rd/data          load return in
//   mem_ready                  FIFO not full
//   WE3/A3/WD3                 registered register-file write port
//   pc_load/pc_target          registered R15 write pulse and data
//   pending_mask               one bit per register with a buffered load
//   stall_count/full_count     perf counters (WB_PERF_COUNT_EN only)
module writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 3,
  parameter int M          = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alu_valid,
  input  logic [3:0]   alu_rd,
  input  logic [M-1:0] alu_data,
  output logic         alu_stall,
  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [3:0]   mem_rd,
  input  logic [M-1:0] mem_data,
  output logic         WE3,
  output logic [3:0]   A3,
  output logic [M-1:0] WD3,
  output logic         pc_load,
  output logic [M-1:0] pc_target,
  output logic [15:0]  pending_mask
`ifdef WB_PERF_COUNT_EN
  ,
  output logic [15:0]  stall_count,
  output logic [15:0]  full_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MAX_STARVE + 1);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] STARVED = 1'b1;

  typedef struct packed {
    logic [3:0]   rd;
    logic [M-1:0] data;
  } wb_ent_t;

  wb_ent_t          ent_q [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt, starve_nxt;
  logic [0:0]       state, state_nxt;

  logic    empty, full, push, pop, forced, alu_win, drain, sel_vld;
  wb_ent_t sel_ent;

  // Empty/full come from registered count only, so a push this cycle is
  // never drainable until the next one.
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign mem_ready = !full;
  assign push      = mem_valid & mem_ready;

  assign forced    = (state == STARVED) && !empty;
  assign alu_win   = !forced && alu_valid;
  assign drain     = !forced && !alu_valid && !empty;
  assign pop       = forced | drain;
  assign alu_stall = forced & alu_valid;
  assign sel_vld   = alu_win | pop;
  assign sel_ent   = alu_win ? wb_ent_t'{rd: alu_rd, data: alu_data} : ent_q[rd_ptr];

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) pending_mask[ent_q[i].rd] = 1'b1;
  end

  // Counter only advances when the ALU beats a non-empty FIFO.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || empty)  starve_nxt = '0;
    else if (alu_win)  starve_nxt = starve_cnt + SW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (starve_nxt == SW'(MAX_STARVE)) state_nxt = STARVED;
      STARVED: if (forced || empty)               state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked in ent_vld.
  always_ff @(posedge clk)
    if (push) ent_q[wr_ptr] <= wb_ent_t'{rd: mem_rd, data: mem_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      state      <= NORMAL;
    end else begin
      if (pop)  begin ent_vld[rd_ptr] <= 1'b0; rd_ptr <= rd_ptr + AW'(1); end
      if (push) begin ent_vld[wr_ptr] <= 1'b1; wr_ptr <= wr_ptr + AW'(1); end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_nxt;
      state      <= state_nxt;
    end
  end

  // R15 diverts to pc_load; A3/WD3 keep their last register-file write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WE3       <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
    end else begin
      WE3     <= 1'b0;
      pc_load <= 1'b0;
      if (sel_vld) begin
        if (sel_ent.rd == 4'd15) begin
          pc_load   <= 1'b1;
          pc_target <= sel_ent.data;
        end else begin
          WE3 <= 1'b1;
          A3  <= sel_ent.rd;
          WD3 <= sel_ent.data;
        end
      end
    end
  end

`ifdef WB_PERF_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      full_count  <= '0;
    end else begin
      if (alu_stall && stall_count != 16'hFFFF)          stall_count <= stall_count + 16'd1;
      if (full && mem_valid && full_count != 16'hFFFF)   full_count  <= full_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file's single write port (WE3/A3/WD3).
- Merges two result sources: a one-cycle ALU result channel, and a variable-latency load-return channel.
- Load returns are buffered in a small FIFO and drained into idle write slots; a starvation guard forces a drain when needed.
- Writes targeting R15 are diverted to a PC-load output, because R15 is driven by the PC path.

Parameters:
- DEPTH, 4, load-return FIFO entries; power of 2, minimum 2.
- MAX_STARVE, 3, consecutive cycles a non-empty FIFO may be bypassed by ALU writes before a drain is forced; minimum 1.
- M, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle (no backpressure, except through alu_stall).
- alu_rd  in  4  ALU destination register.
- alu_data  in  M  ALU result.
- alu_stall  out  1  combinational; ALU result is not taken this cycle and upstream must re-present it.
- mem_valid  in  1  load return offered.
- mem_ready  out  1  combinational; equals !full.
- mem_rd  in  4  load destination register.
- mem_data  in  M  load data.
- WE3  out  1  registered write enable to the register file.
- A3  out  4  registered write address.
- WD3  out  M  registered write data.
- pc_load  out  1  registered one-cycle pulse: write to R15.
- pc_target  out  M  registered R15 write data; valid while pc_load is high.
- pending_mask  out  16  combinational; bit i is set when any FIFO entry targets register i.

Behaviour:
- Reset (reset=0, asynchronous):
  - WE3, A3, WD3, pc_load, pc_target all go to 0.
  - FIFO is emptied (pointers and count 0); buffered loads are discarded.
  - Starvation counter is 0 and the FSM is in NORMAL.
  - Reset asserted mid-operation drops all buffered writes.
- FIFO:
  - Push when mem_valid & mem_ready.
  - mem_ready depends on count only, so there is no push at full even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - A pushed entry becomes drainable no earlier than the next cycle (no flow-through).
- Per-cycle slot selection, one winner:
  - FORCED: state STARVED and FIFO non-empty -> pop head; alu_stall = alu_valid.
  - ALU: otherwise, if alu_valid -> select the ALU result; alu_stall = 0.
  - DRAIN: otherwise, if FIFO non-empty -> pop head.
  - IDLE: otherwise, no write.
- Output register, one cycle after selection:
  - Selected rd != 15: WE3=1, A3=rd, WD3=data, pc_load=0.
  - Selected rd == 15: WE3=0, pc_load=1, pc_target=data; A3/WD3 hold their previous values.
  - IDLE: WE3=0, pc_load=0.
- Latency: ALU result 1 cycle to WE3; load return at least 2 cycles from accept to WE3.
- Starvation counter (width clog2(MAX_STARVE+1)):
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on any pop, or whenever the FIFO is empty.
- FSM:
  - NORMAL -> STARVED when the counter reaches MAX_STARVE.
  - STARVED -> NORMAL after one FORCED pop.
  - STARVED -> NORMAL if the FIFO becomes empty.
- pending_mask: OR of one-hot(rd) over valid entries. It updates in the cycle after a push and in the cycle after a pop; an entry is cleared from the mask in the same cycle its WE3 is presented.
- Same rd in the ALU and FIFO paths: no reordering guarantee. Upstream uses pending_mask to interlock.

Optional Feature:
- WB_PERF_COUNT_EN defined:
  - Adds outputs stall_count[15:0] and full_count[15:0].
  - stall_count counts cycles with alu_stall=1; full_count counts cycles with FIFO full and mem_valid=1.
  - Both are saturating, cleared by reset.
- WB_PERF_COUNT_EN undefined: these ports and counters do not exist.

Test Plan:
- ALU-only path: alu_valid=1, rd=3, data=0x1234 -> next cycle WE3=1, A3=3, WD3=0x1234; mem_ready stays 1.
- Load drain: mem push rd=5, data=0xAA with ALU idle -> pending_mask=0x0020 next cycle; WE3=1, A3=5, WD3=0xAA two cycles after accept; mask returns to 0.
- FIFO full: 5 back-to-back pushes with ALU continuously valid (DEPTH=4) -> mem_ready=0 after the 4th accept; 5th held until a pop; no data loss, order preserved.
- Starvation: FIFO holds rd=7 and ALU is valid for 10 cycles (MAX_STARVE=3) -> 3 ALU writes, then alu_stall=1 for one cycle, then WE3 A3=7; the held ALU result is written the following cycle.
- R15 diversion: ALU rd=15, data=0x100 -> WE3=0, pc_load=1, pc_target=0x100 for exactly one cycle.
- Async reset with 3 entries buffered -> all outputs 0 immediately; after release: pending_mask=0, mem_ready=1, no stale writes.
